// File: rtl/path_sequencer.sv
// path_sequencer
//   Run-time turn scheduler for the line-following motor datapath. A path of
//   up to DEPTH two-bit turn codes is loaded while idle; after `start` the code
//   of the upcoming node is presented on `turn_flag`. The sequencer advances one
//   entry per `node_changed` pulse, and raises `end_path` after the last node or
//   when no node arrives within TIMEOUT cycles.
//
// Ports
//   clk_3125KHz   in   system clock
//   rst_n         in   asynchronous active-low reset
//   wr_en         in   append wr_data to the path (IDLE only)
//   wr_data[1:0]  in   turn code: 0 straight, 1 right, 2 U-turn, 3 left
//   wr_clr        in   empty the path (IDLE and DONE)
//   start         in   begin traversal from entry 0 (IDLE and DONE)
//   abort         in   return to IDLE from any state, path kept
//   node_changed  in   pulse when the bot leaves a node
//   turn_flag     out  turn code for the upcoming node
//   end_path      out  stop-motors request
//   busy          out  traversal in progress
//   timeout_err   out  node timeout fault
//   node_idx      out  index of the current entry
//   path_len      out  number of stored entries (0..DEPTH)
//   wr_full       out  path memory full
module path_sequencer #(
  parameter int DEPTH   = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 31250000
) (
  input  logic             clk_3125KHz,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_data,
  input  logic             wr_clr,
  input  logic             start,
  input  logic             abort,
  input  logic             node_changed,
  output logic [1:0]       turn_flag,
  output logic             end_path,
  output logic             busy,
  output logic             timeout_err,
  output logic [IDX_W-1:0] node_idx,
  output logic [IDX_W:0]   path_len,
  output logic             wr_full
);

  // TIMEOUT is bounded to 2^25, so the last count value fits in 25 bits.
  localparam int                 CNT_W   = 25;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0]     LEN_MAX  = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W:0]   len_next;
  logic             end_next, busy_next, terr_next;

  logic             mem_we;
  logic             load_turn;   // turn_flag <= mem[rd_addr]
  logic             turn_zero;   // turn_flag <= 0
  logic [IDX_W-1:0] rd_addr;
  logic             begin_run;
  logic [IDX_W:0]   idx_plus;

  logic [1:0] mem [DEPTH];

  assign wr_full  = (path_len == LEN_MAX);
  assign idx_plus = {1'b0, node_idx} + 1'b1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = node_idx;
    len_next   = path_len;
    end_next   = end_path;
    busy_next  = busy;
    terr_next  = timeout_err;
    mem_we     = 1'b0;
    load_turn  = 1'b0;
    turn_zero  = 1'b0;
    rd_addr    = '0;
    begin_run  = 1'b0;

    if (abort) begin
      state_next = IDLE;
      end_next   = 1'b0;
      terr_next  = 1'b0;
      busy_next  = 1'b0;
      turn_zero  = 1'b1;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (wr_clr) begin
            len_next = '0;
          end else if (start) begin
            begin_run = 1'b1;
          end else if (wr_en && (path_len < LEN_MAX)) begin
            mem_we   = 1'b1;
            len_next = path_len + 1'b1;
          end
        end
        DONE: begin
          if (wr_clr) begin
            state_next = IDLE;
            len_next   = '0;
            end_next   = 1'b0;
          end else if (start) begin
            begin_run = 1'b1;
          end
        end
        RUN: begin
          // A node arriving on the timeout cycle still counts as in time.
          if (node_changed) begin
            if (idx_plus < path_len) begin
              idx_next  = idx_plus[IDX_W-1:0];
              rd_addr   = idx_plus[IDX_W-1:0];
              load_turn = 1'b1;
              cnt_next  = '0;
            end else begin
              state_next = DONE;
              end_next   = 1'b1;
              busy_next  = 1'b0;
              turn_zero  = 1'b1;
            end
          end else if (cnt_reg == CNT_LAST) begin
            state_next = FAULT;
            terr_next  = 1'b1;
            end_next   = 1'b1;
            busy_next  = 1'b0;
            turn_zero  = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: ; // FAULT leaves only on abort
      endcase

      if (begin_run) begin
        idx_next = '0;
        cnt_next = '0;
        if (path_len == '0) begin
          state_next = DONE;
          end_next   = 1'b1;
          busy_next  = 1'b0;
          turn_zero  = 1'b1;
        end else begin
          state_next = RUN;
          end_next   = 1'b0;
          busy_next  = 1'b1;
          rd_addr    = '0;
          load_turn  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      node_idx    <= '0;
      path_len    <= '0;
      end_path    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      turn_flag   <= 2'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      node_idx    <= idx_next;
      path_len    <= len_next;
      end_path    <= end_next;
      busy        <= busy_next;
      timeout_err <= terr_next;
      if (load_turn)
        turn_flag <= mem[rd_addr];
      else if (turn_zero)
        turn_flag <= 2'd0;
    end
  end

  // Path storage is not reset; path_len alone defines which entries are valid.
  always_ff @(posedge clk_3125KHz) begin
    if (mem_we)
      mem[path_len[IDX_W-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_path_sequencer.sv
module tb_path_sequencer;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int TO    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0, wr_clr = 1'b0, start = 1'b0, abort = 1'b0, node_changed = 1'b0;
  logic [1:0]       wr_data = 2'd0;
  logic [1:0]       turn_flag;
  logic             end_path, busy, timeout_err, wr_full;
  logic [IDX_W-1:0] node_idx;
  logic [IDX_W:0]   path_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  path_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TIMEOUT(TO)) dut (
    .clk_3125KHz(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_clr(wr_clr), .start(start), .abort(abort), .node_changed(node_changed),
    .turn_flag(turn_flag), .end_path(end_path), .busy(busy),
    .timeout_err(timeout_err), .node_idx(node_idx), .path_len(path_len),
    .wr_full(wr_full)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the path is a queue, the mode a plain integer
  // (0 idle, 1 traversing, 2 finished, 3 fault); outputs follow from these.
  bit [1:0] m_path[$];
  int       m_mode = 0;
  int       m_idx  = 0;
  int       m_wait = 0;   // cycles spent waiting for the next node

  task automatic m_begin();
    m_idx  = 0;
    m_wait = 0;
    m_mode = (m_path.size() == 0) ? 2 : 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_path.delete();
      m_mode = 0; m_idx = 0; m_wait = 0;
    end else if (abort) begin
      m_mode = 0; m_idx = 0; m_wait = 0;
    end else begin
      case (m_mode)
        0: if (wr_clr) m_path.delete();
           else if (start) m_begin();
           else if (wr_en && m_path.size() < DEPTH) m_path.push_back(wr_data);
        2: if (wr_clr) begin m_path.delete(); m_mode = 0; end
           else if (start) m_begin();
        1: if (node_changed) begin
             if (m_idx + 1 < m_path.size()) begin m_idx++; m_wait = 0; end
             else m_mode = 2;
           end else if (m_wait + 1 >= TO) m_mode = 3;
           else m_wait++;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_turn",  int'(turn_flag),   (m_mode == 1) ? int'(m_path[m_idx]) : 0);
      chk("cyc_end",   int'(end_path),    (m_mode >= 2) ? 1 : 0);
      chk("cyc_busy",  int'(busy),        (m_mode == 1) ? 1 : 0);
      chk("cyc_terr",  int'(timeout_err), (m_mode == 3) ? 1 : 0);
      chk("cyc_idx",   int'(node_idx),    m_idx);
      chk("cyc_len",   int'(path_len),    m_path.size());
      chk("cyc_full",  int'(wr_full),     (m_path.size() == DEPTH) ? 1 : 0);
    end
  end

  // Inputs change 1 time unit after the falling edge; step() lets one rising
  // edge sample them and returns just after the following falling edge.
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] code);
    wr_en = 1'b1; wr_data = code; step(); wr_en = 1'b0;
  endtask

  task automatic pulse_start();  start = 1'b1;        step(); start = 1'b0;        endtask
  task automatic pulse_node();   node_changed = 1'b1; step(); node_changed = 1'b0; endtask
  task automatic pulse_abort();  abort = 1'b1;        step(); abort = 1'b0;        endtask
  task automatic pulse_clr();    wr_clr = 1'b1;       step(); wr_clr = 1'b0;       endtask

  initial begin
    step(); step();
    chk("rst_turn", int'(turn_flag), 0);
    chk("rst_end",  int'(end_path), 0);
    chk("rst_len",  int'(path_len), 0);
    rst_n = 1'b1;
    step();
    $display("reset released");

    // Basic traversal 1,0,3
    wr(2'd1); wr(2'd0); wr(2'd3);
    chk("load_len", int'(path_len), 3);
    pulse_start();
    chk("start_busy", int'(busy), 1);
    chk("start_turn", int'(turn_flag), 1);
    pulse_node();
    chk("n1_turn", int'(turn_flag), 0);
    chk("n1_idx",  int'(node_idx), 1);
    pulse_node();
    chk("n2_turn", int'(turn_flag), 3);
    pulse_node();
    chk("n3_end",  int'(end_path), 1);
    chk("n3_busy", int'(busy), 0);
    chk("n3_idx",  int'(node_idx), 2);
    $display("traversal 1,0,3 done: end_path=%0d", end_path);

    // Fill past capacity, clear, start empty
    pulse_clr();
    chk("clr_done_len", int'(path_len), 0);
    chk("clr_done_end", int'(end_path), 0);
    for (int i = 0; i < 17; i++) wr(2'(i));
    chk("full_len", int'(path_len), 16);
    chk("full_flag", int'(wr_full), 1);
    pulse_clr();
    chk("clr_len", int'(path_len), 0);
    pulse_start();
    chk("empty_end",  int'(end_path), 1);
    chk("empty_busy", int'(busy), 0);
    $display("overflow/clear/empty-start done");

    // Timeout
    pulse_clr();
    wr(2'd2); wr(2'd1);
    pulse_start();
    repeat (TO - 1) step();
    chk("to_early_terr", int'(timeout_err), 0);
    chk("to_early_busy", int'(busy), 1);
    step();
    chk("to_terr", int'(timeout_err), 1);
    chk("to_end",  int'(end_path), 1);
    pulse_node();
    chk("to_node_ignored", int'(node_idx), 0);
    pulse_abort();
    chk("abort_terr", int'(timeout_err), 0);
    chk("abort_end",  int'(end_path), 0);
    chk("abort_len",  int'(path_len), 2);
    $display("timeout and abort done");

    // Node arriving on the final timeout cycle wins
    pulse_start();
    repeat (TO - 1) step();
    pulse_node();
    chk("race_idx",  int'(node_idx), 1);
    chk("race_terr", int'(timeout_err), 0);
    chk("race_turn", int'(turn_flag), 1);
    pulse_abort();
    // start beats wr_en in IDLE
    start = 1'b1; wr_en = 1'b1; wr_data = 2'd3; step(); start = 1'b0; wr_en = 1'b0;
    chk("sw_busy", int'(busy), 1);
    chk("sw_len",  int'(path_len), 2);
    chk("sw_turn", int'(turn_flag), 2);
    pulse_abort();
    $display("same-cycle priority done");

    // Asynchronous reset mid-run at node 2
    pulse_clr();
    wr(2'd1); wr(2'd2); wr(2'd3); wr(2'd0);
    pulse_start();
    pulse_node(); pulse_node();
    chk("pre_rst_idx",  int'(node_idx), 2);
    chk("pre_rst_turn", int'(turn_flag), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_turn", int'(turn_flag), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_idx",  int'(node_idx), 0);
    chk("arst_len",  int'(path_len), 0);
    chk("arst_end",  int'(end_path), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_len",  int'(path_len), 0);
    chk("post_rst_busy", int'(busy), 0);
    // Write followed immediately by start
    wr(2'd2);
    pulse_start();
    chk("wr_start_turn", int'(turn_flag), 2);
    pulse_node();
    chk("wr_start_end", int'(end_path), 1);
    $display("async reset and write-then-start done");

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected finish earlier");
    $fatal(1);
  end
endmodule
